// File: rtl/iq_upmix_pkg.sv
// Shared types, defaults and helper functions for the iq_upmix complex-to-real mixer.
// Includes the saturating Q1.15 rounder and the quarter-wave sine table generator.
package iq_upmix_pkg;

   localparam int PHASE_W_DEF = 24;
   localparam int LUT_AW_DEF  = 8;

   typedef logic signed [15:0] sample_t;

   // Round half up at bit 15, then clamp the result to the Q1.15 range.
   function automatic sample_t sat_rnd15(input logic signed [32:0] x);
      logic signed [32:0] t;
      logic signed [17:0] s;
      t = x + 33'sd16384;
      s = t[32:15];
      if (s > 18'sd32767) begin
         return 16'sh7fff;
      end else if (s < -18'sd32768) begin
         return 16'sh8000;
      end else begin
         return s[15:0];
      end
   endfunction

   // Half-sample offset keeps every entry strictly positive and the table symmetric.
   function automatic logic [15:0] lut_entry(input int k, input int aw);
      real n;
      real v;
      n = real'(4 * (1 << aw));
      v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / n);
      return 16'($rtoi(v + 0.5));
   endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine/cosine lookup: one table, read at a and N-1-a, sign applied per quadrant.
// Outputs are registered, giving one cycle of latency.
module nco_quarter_lut
   import iq_upmix_pkg::*;
#(
   parameter int LUT_AW = LUT_AW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LUT_AW+1:0]   phase_idx,
   output logic signed [15:0]  sin_out,
   output logic signed [15:0]  cos_out
);

   localparam int N = 1 << LUT_AW;

   logic [15:0]       rom [N];
   logic [1:0]        quad;
   logic [LUT_AW-1:0] addr;
   logic [15:0]       l_fwd;
   logic [15:0]       l_rev;
   logic [15:0]       sin_mag;
   logic [15:0]       cos_mag;
   sample_t           sin_d, sin_q;
   sample_t           cos_d, cos_q;

   for (genvar k = 0; k < N; k++) begin : g_rom
      localparam logic [15:0] VAL = lut_entry(k, LUT_AW);
      assign rom[k] = VAL;
   end

   // cos is sin advanced one quadrant: odd quadrants swap the two reads,
   // and cos is negative in quadrants 1 and 2.
   always_comb begin
      quad    = phase_idx[LUT_AW+1:LUT_AW];
      addr    = phase_idx[LUT_AW-1:0];
      l_fwd   = rom[addr];
      l_rev   = rom[~addr];
      sin_mag = quad[0] ? l_rev : l_fwd;
      cos_mag = quad[0] ? l_fwd : l_rev;
      sin_d   = quad[1] ? sample_t'(16'd0 - sin_mag) : sample_t'(sin_mag);
      cos_d   = (quad[1] ^ quad[0]) ? sample_t'(16'd0 - cos_mag) : sample_t'(cos_mag);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sin_q <= '0;
         cos_q <= '0;
      end else begin
         sin_q <= sin_d;
         cos_q <= cos_d;
      end
   end

   assign sin_out = sin_q;
   assign cos_out = cos_q;

endmodule

// File: rtl/iq_upmix.sv
// Complex-to-real upconverter: dout = re*cos(phi) - im*sin(phi), phi from an internal NCO.
// Fixed four-stage pipeline: phase register, table read, multiply, subtract/round/saturate.
module iq_upmix
   import iq_upmix_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int LUT_AW  = LUT_AW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cke,
   input  logic signed [15:0]  din_re,
   input  logic signed [15:0]  din_im,
   input  logic [PHASE_W-1:0]  fcw,
   input  logic                phase_clr,
   output logic signed [15:0]  dout,
   output logic                cke_out
);

   localparam int PW = LUT_AW + 2;

   // cke and cke_out are plain strobes with no backpressure: every cycle with
   // cke high accepts a sample, and its result appears with cke_out four cycles later.
   logic [PHASE_W-1:0] acc_d, acc_q;
   logic [PW-1:0]      pidx_d, pidx_q;
   sample_t            re1_d, re1_q, im1_d, im1_q;
   sample_t            re2_d, re2_q, im2_d, im2_q;
   logic signed [31:0] prod_re_d, prod_re_q;
   logic signed [31:0] prod_im_d, prod_im_q;
   logic [3:0]         vld_d, vld_q;
   sample_t            dout_d, dout_q;
   sample_t            sin_s2, cos_s2;
   logic signed [32:0] diff;

   nco_quarter_lut #(.LUT_AW(LUT_AW)) u_lut (
      .clk       (clk),
      .rst_n     (rst),
      .phase_idx (pidx_q),
      .sin_out   (sin_s2),
      .cos_out   (cos_s2)
   );

   // The sample uses the pre-update accumulator; a clear alongside cke forces phase 0.
   always_comb begin
      acc_d = acc_q;
      if (phase_clr && cke) begin
         acc_d = fcw;
      end else if (phase_clr) begin
         acc_d = '0;
      end else if (cke) begin
         acc_d = acc_q + fcw;
      end
      pidx_d    = phase_clr ? '0 : acc_q[PHASE_W-1 -: PW];
      re1_d     = din_re;
      im1_d     = din_im;
      re2_d     = re1_q;
      im2_d     = im1_q;
      prod_re_d = re2_q * cos_s2;
      prod_im_d = im2_q * sin_s2;
      diff      = 33'(prod_re_q) - 33'(prod_im_q);
      vld_d     = {vld_q[2:0], cke};
      dout_d    = vld_q[2] ? sat_rnd15(diff) : dout_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q     <= '0;
         pidx_q    <= '0;
         re1_q     <= '0;
         im1_q     <= '0;
         re2_q     <= '0;
         im2_q     <= '0;
         prod_re_q <= '0;
         prod_im_q <= '0;
         vld_q     <= '0;
         dout_q    <= '0;
      end else begin
         acc_q     <= acc_d;
         pidx_q    <= pidx_d;
         re1_q     <= re1_d;
         im1_q     <= im1_d;
         re2_q     <= re2_d;
         im2_q     <= im2_d;
         prod_re_q <= prod_re_d;
         prod_im_q <= prod_im_d;
         vld_q     <= vld_d;
         dout_q    <= dout_d;
      end
   end

   assign dout    = dout_q;
   assign cke_out = vld_q[3];

endmodule

// File: tb/tb_iq_upmix.sv
// Directed bench for iq_upmix: hand-computed expected outputs queued per sample,
// popped by a monitor on every cke_out, plus reset and latency checks.
module tb_iq_upmix;

   logic               clk = 1'b0;
   logic               rst;
   logic               cke;
   logic signed [15:0] din_re;
   logic signed [15:0] din_im;
   logic [23:0]        fcw;
   logic               phase_clr;
   logic signed [15:0] dout;
   logic               cke_out;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          out_idx  = 0;
   logic [15:0] exp_q[$];

   localparam logic [23:0] F_QTR  = 24'h400000;
   localparam logic [23:0] F_HALF = 24'h800000;
   localparam logic [23:0] F_ODD  = 24'd12345;

   logic signed [15:0] tone_exp [4] = '{16'sd16384, -16'sd50, -16'sd16383, 16'sd51};
   logic signed [15:0] quad_exp [4] = '{-16'sd50, -16'sd16383, 16'sd51, 16'sd16384};

   always #5 clk = ~clk;

   iq_upmix dut (
      .clk       (clk),
      .rst       (rst),
      .cke       (cke),
      .din_re    (din_re),
      .din_im    (din_im),
      .fcw       (fcw),
      .phase_clr (phase_clr),
      .dout      (dout),
      .cke_out   (cke_out)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One cke cycle; the expected output is queued for the monitor.
   task automatic send(input logic signed [15:0] re, input logic signed [15:0] im,
                       input logic [23:0] f, input logic clr, input logic signed [15:0] e);
      cke       = 1'b1;
      din_re    = re;
      din_im    = im;
      fcw       = f;
      phase_clr = clr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cke       = 1'b0;
      phase_clr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && cke_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_cke_out", 32'sd1, 32'sd0);
         end else begin
            check($sformatf("dout#%0d", out_idx), 32'(dout), 32'($signed(exp_q.pop_front())));
            out_idx++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      cke       = 1'b0;
      din_re    = '0;
      din_im    = '0;
      fcw       = '0;
      phase_clr = 1'b0;
      idle(2);

      // Strobes during reset must not reach the output.
      cke    = 1'b1;
      din_re = 16'sd16384;
      idle(3);
      check("rst_dout", 32'(dout), 32'sd0);
      check("rst_cke_out", 32'(cke_out), 32'sd0);
      cke = 1'b0;

      // First cke on the first edge after release; latency is exactly four cycles.
      rst = 1'b1;
      send(16'sd16384, 16'sd0, 24'd0, 1'b0, 16'sd16384);
      idle(2);
      check("lat_early", 32'(cke_out), 32'sd0);
      idle(1);
      check("lat_exact", 32'(cke_out), 32'sd1);
      idle(1);
      check("lat_single", 32'(cke_out), 32'sd0);
      idle(3);

      // fs/4 tone on I only, continuous strobes.
      for (int i = 0; i < 8; i++) begin
         send(16'sd16384, 16'sd0, F_QTR, (i == 0), tone_exp[i % 4]);
      end
      // Same tone on Q only: the Q term enters with a minus sign.
      for (int i = 0; i < 4; i++) begin
         send(16'sd0, 16'sd16384, F_QTR, (i == 0), quad_exp[i]);
      end
      // Full-scale inputs at phase 0 and pi: both ends clamp.
      send(-16'sd32768, 16'sd32767, F_HALF, 1'b1, -16'sd32768);
      send(-16'sd32768, 16'sd32767, F_HALF, 1'b0, 16'sd32767);

      // phase_clr with cke: sample at phase 0, accumulator restarts at fcw.
      send(16'sd16384, 16'sd16384, F_ODD, 1'b1, 16'sd16333);
      send(16'sd16384, 16'sd16384, F_ODD, 1'b0, 16'sd16333);
      send(16'sd16384, 16'sd16384, F_ODD, 1'b0, 16'sd16232);
      for (int i = 0; i < 7; i++) begin
         send(16'sd0, 16'sd0, F_ODD, 1'b0, 16'sd0);
      end
      send(16'sd16384, 16'sd16384, F_ODD, 1'b1, 16'sd16333);
      send(16'sd16384, 16'sd16384, F_ODD, 1'b0, 16'sd16333);
      send(16'sd16384, 16'sd16384, F_ODD, 1'b0, 16'sd16232);

      // phase_clr alone zeroes the accumulator.
      phase_clr = 1'b1;
      idle(1);
      phase_clr = 1'b0;
      send(16'sd16384, 16'sd16384, F_ODD, 1'b0, 16'sd16333);
      send(16'sd16384, 16'sd16384, F_ODD, 1'b0, 16'sd16333);
      send(16'sd16384, 16'sd16384, F_ODD, 1'b0, 16'sd16232);
      idle(8);
      check("drain", 32'(exp_q.size()), 32'sd0);
      check("hold_dout", 32'(dout), 32'sd16232);

      // Reset two cycles after a strobe: the sample is dropped, dout clears at once.
      cke    = 1'b1;
      din_re = 16'sd16384;
      din_im = 16'sd0;
      fcw    = 24'd0;
      idle(1);
      cke = 1'b0;
      idle(1);
      rst = 1'b0;
      #1;
      check("mid_rst_dout", 32'(dout), 32'sd0);
      check("mid_rst_cke_out", 32'(cke_out), 32'sd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(8);
      check("mid_rst_after", 32'(dout), 32'sd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
